// File: rtl/lfsr_encrypt_engine.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// lfsr_encrypt_engine : pads a plaintext message with '_' and XORs it with a
// 6-bit LFSR stream into mem[64:127]. Optional build macro: PARITY_EN.
// Revision: 1.0
// =============================================================================
module lfsr_encrypt_engine #(
  parameter int MSG_MAX  = 50,
  parameter int OUT_BASE = 64,
  parameter int CFG_BASE = 61
) (
  input  logic       clk,
  input  logic       i_init,
  output logic [7:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] c_pad_byte = 8'h5F;
  localparam logic [5:0] c_last_idx = 6'd63;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cfg_cnt;
  logic [3:0]  r_pre;
  logic [5:0]  r_taps;
  logic [5:0]  r_lfsr;
  logic [5:0]  r_idx;
  logic        r_phase;
  logic        r_term;
  logic        r_use_mem;
  logic [7:0]  r_rd_addr;
  logic        r_wr_en;
  logic [7:0]  r_wr_addr;
  logic        r_done;

  logic        w_term_now;
  logic [6:0]  w_next_byte;
  logic [6:0]  w_k;
  logic        w_need;
  logic [3:0]  w_pre_san;
  logic [5:0]  w_taps_san;
  logic [5:0]  w_init_san;
  logic [5:0]  w_lfsr_nxt;
  logic [7:0]  w_plain;
  logic [7:0]  w_cipher;

  always_ff @(posedge clk) begin
    if (i_init) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_CFG;
      S_CFG:  if (r_cfg_cnt == 2'd3) w_state_nxt = S_RUN;
      S_RUN:  if (r_phase && (r_idx == c_last_idx)) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A terminator is only discovered when its byte reaches the write cycle.
  assign w_term_now  = (r_state == S_RUN) && r_phase && r_use_mem && (i_rd_data == 8'h00);
  assign w_next_byte = (r_state == S_RUN) ? ({1'b0, r_idx} + 7'd1) : 7'd0;
  assign w_k         = w_next_byte - {3'b000, r_pre};
  assign w_need      = (w_next_byte >= {3'b000, r_pre}) && (w_k < 7'(MSG_MAX))
                       && !(r_term || w_term_now);

  assign w_pre_san  = ((i_rd_data < 8'd7) || (i_rd_data > 8'd12)) ? 4'd7 : i_rd_data[3:0];
  assign w_init_san = (i_rd_data[5:0] == 6'd0) ? 6'h01 : i_rd_data[5:0];

  always_comb begin
    w_taps_san = 6'h33;
    case (i_rd_data[2:0])
      3'd0:    w_taps_san = 6'h21;
      3'd1:    w_taps_san = 6'h2D;
      3'd2:    w_taps_san = 6'h30;
      3'd3:    w_taps_san = 6'h33;
      3'd4:    w_taps_san = 6'h36;
      3'd5:    w_taps_san = 6'h39;
      default: w_taps_san = 6'h33;
    endcase
  end

  assign w_lfsr_nxt = {r_lfsr[4:0], ^(r_lfsr & r_taps)};
  assign w_plain    = (r_use_mem && (i_rd_data != 8'h00)) ? i_rd_data : c_pad_byte;

`ifdef PARITY_EN
  logic [6:0] w_low7;
  assign w_low7   = w_plain[6:0] ^ {1'b0, r_lfsr};
  assign w_cipher = {^w_low7, w_low7};
`else
  assign w_cipher = w_plain ^ {2'b00, r_lfsr};
`endif

  always_ff @(posedge clk) begin
    if (i_init) begin
      r_cfg_cnt <= 2'd0;
      r_pre     <= 4'd0;
      r_taps    <= 6'd0;
      r_lfsr    <= 6'd0;
      r_idx     <= 6'd0;
      r_phase   <= 1'b0;
      r_term    <= 1'b0;
      r_use_mem <= 1'b0;
      r_rd_addr <= 8'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 8'd0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cfg_cnt <= 2'd0;
          r_rd_addr <= 8'(CFG_BASE);
        end
        S_CFG: begin
          r_cfg_cnt <= r_cfg_cnt + 2'd1;
          case (r_cfg_cnt)
            2'd0: r_rd_addr <= 8'(CFG_BASE + 1);
            2'd1: begin
              r_pre     <= w_pre_san;
              r_rd_addr <= 8'(CFG_BASE + 2);
            end
            2'd2: r_taps <= w_taps_san;
            default: begin
              r_lfsr    <= w_init_san;
              r_idx     <= 6'd0;
              r_phase   <= 1'b0;
              r_term    <= 1'b0;
              r_use_mem <= w_need;
              r_rd_addr <= w_need ? {1'b0, w_k} : 8'd0;
            end
          endcase
        end
        S_RUN: begin
          if (!r_phase) begin
            r_phase   <= 1'b1;
            r_wr_en   <= 1'b1;
            r_wr_addr <= 8'(OUT_BASE) + {2'b00, r_idx};
            r_rd_addr <= 8'd0;
          end else begin
            r_wr_en <= 1'b0;
            r_lfsr  <= w_lfsr_nxt;
            r_term  <= r_term | w_term_now;
            if (r_idx == c_last_idx) begin
              r_done    <= 1'b1;
              r_use_mem <= 1'b0;
              r_rd_addr <= 8'd0;
            end else begin
              r_idx     <= r_idx + 6'd1;
              r_phase   <= 1'b0;
              r_use_mem <= w_need;
              r_rd_addr <= w_need ? {1'b0, w_k} : 8'd0;
            end
          end
        end
        S_DONE: begin
          r_wr_en <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign o_rd_addr = r_rd_addr;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_en ? w_cipher : 8'h00;
  assign o_done    = r_done;

endmodule
`default_nettype wire
